// File: rtl/router_dut.sv
// Store-and-forward packet router: buffers one byte-serial packet, validates
// length, size limits and payload checksum, then replays it unchanged.
module router_dut #(
    parameter int MIN_PKT = 12,
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dut_inp,
    input  logic       inp_valid,
    output logic [7:0] dut_outp,
    output logic       outp_valid,
    output logic       busy,
    output logic [3:0] error
);

    localparam int AW = $clog2(MAX_PKT);
    localparam int CW = $clog2(MAX_PKT + 1);

    localparam logic [3:0] ERR_OK    = 4'd0;
    localparam logic [3:0] ERR_PROTO = 4'd1;
    localparam logic [3:0] ERR_CRC   = 4'd2;
    localparam logic [3:0] ERR_SHORT = 4'd3;
    localparam logic [3:0] ERR_LONG  = 4'd4;
    localparam logic [3:0] ERR_LEN   = 4'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        CHECK    = 2'd2,
        TRANSMIT = 2'd3
    } state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   count_r, count_nxt_s;
    logic [CW-1:0]   rd_ptr_r, rd_ptr_nxt_s;
    logic [31:0]     len_r, len_nxt_s;
    logic [31:0]     crc_r, crc_nxt_s;
    logic [7:0]      sum_r, sum_nxt_s;
    logic            drain_r, drain_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic [3:0]      error_r, error_nxt_s;
    logic [7:0]      outp_r, outp_nxt_s;
    logic            outp_valid_r, outp_valid_nxt_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_addr_s;
    logic [7:0]      mem_r [MAX_PKT];

    // Next-state and datapath control for the receive/check/transmit sequence.
    always_comb begin
        state_nxt_s      = state_r;
        count_nxt_s      = count_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        len_nxt_s        = len_r;
        crc_nxt_s        = crc_r;
        sum_nxt_s        = sum_r;
        drain_nxt_s      = drain_r;
        busy_nxt_s       = busy_r;
        error_nxt_s      = error_r;
        outp_nxt_s       = outp_r;
        outp_valid_nxt_s = outp_valid_r;
        wr_en_s          = 1'b0;
        wr_addr_s        = count_r[AW-1:0];
        case (state_r)
            IDLE: begin
                if (!inp_valid) begin
                    drain_nxt_s = 1'b0;
                end else if (drain_r) begin
                    // Tail of an oversize packet: swallow it silently.
                    drain_nxt_s = 1'b1;
                end else begin
                    wr_en_s     = 1'b1;
                    wr_addr_s   = '0;
                    count_nxt_s = CW'(1);
                    len_nxt_s   = 32'd0;
                    crc_nxt_s   = 32'd0;
                    sum_nxt_s   = 8'd0;
                    busy_nxt_s  = 1'b1;
                    error_nxt_s = ERR_OK;
                    state_nxt_s = RECEIVE;
                end
            end
            RECEIVE: begin
                if (!inp_valid) begin
                    state_nxt_s = CHECK;
                end else if (count_r >= CW'(MAX_PKT)) begin
                    error_nxt_s = ERR_LONG;
                    busy_nxt_s  = 1'b0;
                    drain_nxt_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    wr_en_s     = 1'b1;
                    count_nxt_s = count_r + CW'(1);
                    case (count_r)
                        CW'(2):  len_nxt_s[7:0]   = dut_inp;
                        CW'(3):  len_nxt_s[15:8]  = dut_inp;
                        CW'(4):  len_nxt_s[23:16] = dut_inp;
                        CW'(5):  len_nxt_s[31:24] = dut_inp;
                        CW'(6):  crc_nxt_s[7:0]   = dut_inp;
                        CW'(7):  crc_nxt_s[15:8]  = dut_inp;
                        CW'(8):  crc_nxt_s[23:16] = dut_inp;
                        CW'(9):  crc_nxt_s[31:24] = dut_inp;
                        default: begin
                            if (count_r >= CW'(10)) begin
                                sum_nxt_s = csum_add(sum_r, dut_inp);
                            end else begin
                                sum_nxt_s = sum_r;
                            end
                        end
                    endcase
                end
            end
            CHECK: begin
                if (32'(count_r) != len_r) begin
                    error_nxt_s = ERR_LEN;
                end else if (count_r < CW'(MIN_PKT)) begin
                    error_nxt_s = ERR_SHORT;
                end else if (count_r > CW'(MAX_PKT)) begin
                    error_nxt_s = ERR_LONG;
                end else if (crc_r != {24'd0, sum_r}) begin
                    error_nxt_s = ERR_CRC;
                end else if (inp_valid) begin
                    error_nxt_s = ERR_PROTO;
                end else begin
                    error_nxt_s = error_r;
                end
                if ((32'(count_r) != len_r) || (count_r < CW'(MIN_PKT)) ||
                    (count_r > CW'(MAX_PKT)) || (crc_r != {24'd0, sum_r})) begin
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    outp_nxt_s       = mem_r[0];
                    outp_valid_nxt_s = 1'b1;
                    rd_ptr_nxt_s     = CW'(1);
                    state_nxt_s      = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (inp_valid) begin
                    error_nxt_s = ERR_PROTO;
                end else begin
                    error_nxt_s = error_r;
                end
                if (rd_ptr_r == count_r) begin
                    outp_nxt_s       = 8'd0;
                    outp_valid_nxt_s = 1'b0;
                    busy_nxt_s       = 1'b0;
                    state_nxt_s      = IDLE;
                end else begin
                    outp_nxt_s   = mem_r[rd_ptr_r[AW-1:0]];
                    rd_ptr_nxt_s = rd_ptr_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            count_r      <= '0;
            rd_ptr_r     <= '0;
            len_r        <= 32'd0;
            crc_r        <= 32'd0;
            sum_r        <= 8'd0;
            drain_r      <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 4'd0;
            outp_r       <= 8'd0;
            outp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            len_r        <= len_nxt_s;
            crc_r        <= crc_nxt_s;
            sum_r        <= sum_nxt_s;
            drain_r      <= drain_nxt_s;
            busy_r       <= busy_nxt_s;
            error_r      <= error_nxt_s;
            outp_r       <= outp_nxt_s;
            outp_valid_r <= outp_valid_nxt_s;
        end
    end

    // Packet buffer; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= dut_inp;
        end
    end

    assign dut_outp   = outp_r;
    assign outp_valid = outp_valid_r;
    assign busy       = busy_r;
    assign error      = error_r;

endmodule

// File: tb/tb_router_dut.sv
// Scoreboard bench for router_dut: expected bytes are queued as good packets
// are driven and checked against dut_outp by a negedge monitor.
module tb_router_dut;

    logic       clk;
    logic       reset;
    logic [7:0] dut_inp;
    logic       inp_valid;
    logic [7:0] dut_outp;
    logic       outp_valid;
    logic       busy;
    logic [3:0] error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];

    router_dut #(.MIN_PKT(12), .MAX_PKT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .dut_inp   (dut_inp),
        .inp_valid (inp_valid),
        .dut_outp  (dut_outp),
        .outp_valid(outp_valid),
        .busy      (busy),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every valid byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && outp_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %02h, expected no output", dut_outp);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dut_outp !== e) begin
                    n_fail++;
                    $display("FAIL out_byte: got %02h, expected %02h", dut_outp, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_pkt(input logic [7:0] sa, input logic [7:0] da, input int plen,
                             input int len_field, input int crc_delta);
        logic [7:0] pay[$];
        int sum;
        logic [31:0] crc;
        logic [31:0] lf;
        sum = 0;
        for (int i = 0; i < plen; i++) begin
            pay.push_back(8'($urandom_range(0, 255)));
            sum += int'(pay[i]);
        end
        crc = 32'(sum % 256 + crc_delta);
        lf  = 32'(len_field);
        pkt_q.delete();
        pkt_q.push_back(sa);
        pkt_q.push_back(da);
        for (int i = 0; i < 4; i++) pkt_q.push_back(lf[8*i +: 8]);
        for (int i = 0; i < 4; i++) pkt_q.push_back(crc[8*i +: 8]);
        foreach (pay[i]) pkt_q.push_back(pay[i]);
    endtask

    task automatic expect_pkt();
        foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
    endtask

    task automatic send_pkt();
        foreach (pkt_q[i]) begin
            dut_inp   = pkt_q[i];
            inp_valid = 1'b1;
            tick();
        end
        inp_valid = 1'b0;
        dut_inp   = 8'd0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            tick();
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_timeout: busy=%b, expected 0", name, busy);
        end
    endtask

    task automatic check_err(input string name, input logic [3:0] exp);
        n_tests++;
        if (error !== exp) begin
            n_fail++;
            $display("FAIL %s_error: got %0d, expected %0d", name, error, exp);
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_output: %0d bytes not seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inp_valid = 1'b0;
        dut_inp = 8'd0;
        repeat (3) tick();
        n_tests++;
        if ({dut_outp, outp_valid, busy, error} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: outp=%02h v=%b busy=%b err=%0d, expected all 0",
                     dut_outp, outp_valid, busy, error);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int cnt;
        build_pkt(8'd3, 8'd5, 12, 22, 0);
        expect_pkt();
        send_pkt();
        tick();
        n_tests++;
        if (outp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: outp_valid=%b one edge after drop, expected 0", outp_valid);
        end
        tick();
        n_tests++;
        if (outp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: outp_valid=%b two edges after drop, expected 1", outp_valid);
        end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (outp_valid) cnt++;
            else break;
        end
        n_tests++;
        if (cnt != 22) begin
            n_fail++;
            $display("FAIL basic_valid_cycles: got %0d, expected 22", cnt);
        end
        n_tests++;
        if (busy !== 1'b0 || dut_outp !== 8'd0) begin
            n_fail++;
            $display("FAIL basic_busy_fall: busy=%b outp=%02h, expected 0/00", busy, dut_outp);
        end
        check_err("basic", 4'd0);
        check_sb_empty("basic");
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 10; p++) begin
            int plen;
            plen = int'($urandom_range(10, 20));
            wait_idle("b2b");
            repeat (5) tick();
            build_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), plen, plen + 10, 0);
            expect_pkt();
            send_pkt();
        end
        wait_idle("b2b_end");
        tick();
        check_err("b2b", 4'd0);
        check_sb_empty("b2b");
    endtask

    task automatic test_bad(input string name, input int plen, input int len_field,
                            input int crc_delta, input logic [3:0] exp_err);
        repeat (3) tick();
        build_pkt(8'd1, 8'd2, plen, len_field, crc_delta);
        send_pkt();
        wait_idle(name);
        repeat (4) tick();
        check_err(name, exp_err);
        check_sb_empty(name);
    endtask

    task automatic test_oversize();
        repeat (3) tick();
        build_pkt(8'd7, 8'd8, 60, 70, 0);
        for (int i = 0; i < 70; i++) begin
            dut_inp   = pkt_q[i];
            inp_valid = 1'b1;
            tick();
            if (i == 63) begin
                n_tests++;
                if (busy !== 1'b1 || error !== 4'd0) begin
                    n_fail++;
                    $display("FAIL long_at64: busy=%b err=%0d, expected 1/0", busy, error);
                end
            end
            if (i == 64) begin
                n_tests++;
                if (busy !== 1'b0 || error !== 4'd4) begin
                    n_fail++;
                    $display("FAIL long_at65: busy=%b err=%0d, expected 0/4", busy, error);
                end
            end
        end
        inp_valid = 1'b0;
        repeat (4) tick();
        check_err("long_end", 4'd4);
        check_sb_empty("long");
    endtask

    task automatic test_protocol();
        repeat (3) tick();
        build_pkt(8'd9, 8'd10, 6, 16, 0);
        expect_pkt();
        send_pkt();
        for (int i = 0; i < 20; i++) begin
            if (outp_valid) break;
            tick();
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            dut_inp   = 8'hA5;
            inp_valid = 1'b1;
            tick();
        end
        inp_valid = 1'b0;
        dut_inp   = 8'd0;
        wait_idle("proto");
        tick();
        check_err("proto", 4'd1);
        check_sb_empty("proto");
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        build_pkt(8'd4, 8'd4, 10, 20, 0);
        for (int i = 0; i < 6; i++) begin
            dut_inp   = pkt_q[i];
            inp_valid = 1'b1;
            tick();
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({dut_outp, outp_valid, busy, error} !== 14'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: outp=%02h v=%b busy=%b err=%0d, expected all 0",
                     dut_outp, outp_valid, busy, error);
        end
        inp_valid = 1'b0;
        dut_inp   = 8'd0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (30) tick();
        n_tests++;
        if (busy !== 1'b0 || error !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_after: busy=%b err=%0d, expected 0/0", busy, error);
        end
        check_sb_empty("midreset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad("crc", 12, 22, 1, 4'd2);
        test_bad("lenfield", 14, 25, 0, 4'd5);
        test_bad("short", 1, 11, 0, 4'd3);
        test_oversize();
        test_protocol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_dut.md
Name: router_dut

Overview:
- Single-port store-and-forward packet router.
- Accepts a byte-serial packet on dut_inp while inp_valid is high and buffers it.
- Checks length, size limits and checksum, then replays the identical byte stream on dut_outp with outp_valid.
- Bad packets are dropped and reported on error; busy provides input-side flow control.

Parameters:
- MIN_PKT, 12, minimum legal packet size in bytes (header 10 + at least 2 payload bytes).
- MAX_PKT, 64, maximum legal packet size in bytes; sets buffer depth.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- dut_inp  input  8  input byte.
- inp_valid  input  1  high for every cycle a packet byte is present; contiguous per packet.
- dut_outp  output  8  output byte.
- outp_valid  output  1  high for every cycle a valid output byte is present.
- busy  output  1  high from the first accepted input byte until the last output byte.
- error  output  4  status code: 0 ok, 1 protocol violation, 2 CRC mismatch, 3 below MIN_PKT, 4 above MAX_PKT, 5 length-field mismatch.

Behaviour:
- Reset (reset=0, asynchronous): dut_outp=0, outp_valid=0, busy=0, error=0, state=IDLE, byte counter and buffer pointers cleared. Reset mid-packet aborts the packet and emits no output.
- Packet byte order on the wire:
  - byte0 = sa, byte1 = da.
  - bytes2-5 = len, 32-bit little-endian, equal to total byte count.
  - bytes6-9 = crc, 32-bit little-endian.
  - bytes10..len-1 = payload.
- CRC rule: crc must equal the 8-bit modulo-256 sum of all payload bytes, zero-extended to 32 bits.
- States: IDLE, RECEIVE, CHECK, TRANSMIT.
- IDLE: at a clk edge with inp_valid=1:
  - store dut_inp as byte0, count=1, busy=1, error=0, go to RECEIVE.
- RECEIVE: each edge with inp_valid=1:
  - store byte, count++, and accumulate the payload sum for bytes at index ≥10.
  - If count would exceed MAX_PKT: drop the packet, set error=4, go IDLE (busy=0); ignore remaining bytes until inp_valid falls.
  - First edge with inp_valid=0: go to CHECK.
- CHECK (one cycle). Priority order:
  - count≠len → error 5.
  - count<MIN_PKT → error 3.
  - count>MAX_PKT → error 4.
  - crc mismatch → error 2.
  - Any failure: drop the packet, busy=0, go IDLE.
  - Otherwise go TRANSMIT.
- TRANSMIT:
  - On the edge leaving CHECK: outp_valid=1 and dut_outp=byte0.
  - Each following edge presents the next byte; exactly len bytes, contiguous, unchanged and in order.
  - On the edge after the last byte: outp_valid=0, dut_outp=0, busy=0, go IDLE.
- Latency: last input byte sampled at edge N; inp_valid=0 sampled at N+1 (enter CHECK); byte0 valid on outputs after N+2.
- Protocol violation: inp_valid=1 while state is CHECK or TRANSMIT:
  - error=1 (set on the first such edge).
  - Those input bytes are ignored.
  - The packet being transmitted completes normally.
- error is registered. It holds its value until the next packet's first byte is accepted in IDLE, or until reset.
- Back-to-back packets: a new packet may start on the first edge with busy=0 and inp_valid=1.
- Buffer: MAX_PKT×8 storage. The same packet is never read and written at once.

Test Plan:
- Reset, then a packet sa=3, da=5, 12-byte payload (len=22, crc=byte-sum mod 256) → same 22 bytes on dut_outp, outp_valid high exactly 22 cycles, first byte 2 cycles after inp_valid falls, error=0, busy falls with outp_valid.
- Ten random packets, payload 10–20 bytes, driven only when busy=0 with a 5-cycle gap → ten output packets match the inputs byte-for-byte, error stays 0.
- Packet with crc field = correct sum+1 → no outp_valid, error=2, busy returns to 0.
- Packet whose len field says 25 but 24 bytes are driven → error=5, no output.
- 11-byte packet (len=11) → error=3; 70-byte packet → error=4 when byte 65 arrives, no output.
- inp_valid raised during TRANSMIT → error=1, current packet still output intact. Reset asserted mid-RECEIVE → all outputs 0 immediately, nothing emitted.
